// File: rtl/ifetch_if.sv
// Signal bundle between ifetch_unit, its instruction memory and the pipeline.
// master = fetch unit side, slave = memory/pipeline side.
interface ifetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [15:0] fetch_count;

  modport master (
    output imem_addr, instr, instr_pc, instr_valid, fetch_count,
    input  imem_data, stall, branch_en, branch_target
  );

  modport slave (
    input  imem_addr, instr, instr_pc, instr_valid, fetch_count,
    output imem_data, stall, branch_en, branch_target
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: sequential fetch, stall hold, branch redirect with one flush slot.
// Optional macro IFETCH_JUMP_EN: resolve J-format jumps directly in fetch.
module ifetch_unit #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     reset,
  ifetch_if.master bus
);

  // Word-aligned address mask for the memory size (IMEM_WORDS is a power of two).
  localparam logic [31:0] ADDR_MASK = 32'(IMEM_WORDS * 4) - 32'd4;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;
  logic [31:0] seq_next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    seq_next_pc = pc_plus4 & ADDR_MASK;
`ifdef IFETCH_JUMP_EN
    if (bus.imem_data[31:26] == 6'b000010)
      seq_next_pc = {pc_plus4[31:28], bus.imem_data[25:0], 2'b00} & ADDR_MASK;
`endif
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH, HOLD: begin
        if (bus.branch_en) begin
          // Redirect beats stall; the slot already in instr is flushed.
          pc_d    = bus.branch_target & ADDR_MASK;
          instr_d = '0;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (bus.stall) begin
          state_d = HOLD;
        end else if (state_q == HOLD) begin
          state_d = FETCH;
        end else begin
          instr_d = bus.imem_data;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = seq_next_pc;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & ADDR_MASK;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_count = cnt_q;

endmodule
